// File: rtl/bldc_pkg.sv
// Shared definitions for the BLDC commutation front end.
// Contents:
//   HALL_S0..HALL_S5  legal Hall codes {H3,H2,H1} in forward rotation order
//   HALL_LO/HALL_HI   the two illegal codes (all sensors low / all high)
//   SECTOR_NONE       sector value reported while no legal code is held
//   ST_ACQUIRE/TRACK  conditioner FSM state encoding
//   hall_legal, hall_to_sector, sector_next, sector_prev  decode helpers
package bldc_pkg;

   localparam logic [2:0] HALL_S0 = 3'b001;
   localparam logic [2:0] HALL_S1 = 3'b101;
   localparam logic [2:0] HALL_S2 = 3'b100;
   localparam logic [2:0] HALL_S3 = 3'b110;
   localparam logic [2:0] HALL_S4 = 3'b010;
   localparam logic [2:0] HALL_S5 = 3'b011;
   localparam logic [2:0] HALL_LO = 3'b000;
   localparam logic [2:0] HALL_HI = 3'b111;

   localparam logic [2:0] SECTOR_NONE = 3'd7;

   localparam logic [0:0] ST_ACQUIRE = 1'b0;
   localparam logic [0:0] ST_TRACK   = 1'b1;

   function automatic logic hall_legal(input logic [2:0] code);
      return (code != HALL_LO) && (code != HALL_HI);
   endfunction

   function automatic logic [2:0] hall_to_sector(input logic [2:0] code);
      case (code)
         HALL_S0: return 3'd0;
         HALL_S1: return 3'd1;
         HALL_S2: return 3'd2;
         HALL_S3: return 3'd3;
         HALL_S4: return 3'd4;
         HALL_S5: return 3'd5;
         default: return SECTOR_NONE;
      endcase
   endfunction

   function automatic logic [2:0] sector_next(input logic [2:0] s);
      return (s == 3'd5) ? 3'd0 : s + 3'd1;
   endfunction

   function automatic logic [2:0] sector_prev(input logic [2:0] s);
      return (s == 3'd0) ? 3'd5 : s - 3'd1;
   endfunction

endpackage

// File: rtl/hall_debounce.sv
// Two-flop synchronizer plus candidate/counter debouncer for the 3-bit Hall bus.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   raw_i[2:0]   raw asynchronous Hall inputs {H3,H2,H1}
//   code_o[2:0]  debounced code
//   accept_o     1-cycle strobe, high in the cycle code_o takes a new value
// A code is accepted once DEBOUNCE_CYC consecutive identical synchronized samples
// have been seen (DEBOUNCE_CYC >= 2).
module hall_debounce #(
   parameter int DEBOUNCE_CYC = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] raw_i,
   output logic [2:0] code_o,
   output logic       accept_o
);

   localparam int CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);
   // The counter is about to reach CNT_MAX with the current sample, so this
   // sample is the DEBOUNCE_CYC-th identical one.
   localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(DEBOUNCE_CYC - 2);

   logic [2:0]       sync1_q, sync2_q;
   logic [2:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       code_q, code_d;
   logic             accept_q, accept_d;

   always_comb begin
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      code_d   = code_q;
      accept_d = 1'b0;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else begin
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
         if ((cnt_q >= CNT_ARM) && (cand_q != code_q)) begin
            code_d   = cand_q;
            accept_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         cand_q   <= '0;
         cnt_q    <= '0;
         code_q   <= '0;
         accept_q <= 1'b0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         code_q   <= code_d;
         accept_q <= accept_d;
      end
   end

   assign code_o   = code_q;
   assign accept_o = accept_q;

endmodule

// File: rtl/hall_sensor_conditioner.sv
// Hall sensor front end for BLDC commutation: debounced code, rotor sector,
// direction, edge strobe, edge-to-edge period, illegal-code fault, sequence-skip
// strobe and stall detection.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   H1, H2, H3          raw asynchronous Hall inputs
//   hall_code[2:0]      debounced {H3,H2,H1}
//   sector[2:0]         0..5, or 7 when no legal code is held
//   sector_valid        debounced code is legal
//   edge_pulse          1-cycle strobe on an adjacent sector change
//   dir                 1 = forward, 0 = reverse
//   period[PERIOD_W-1:0] clk cycles between the last two edge strobes
//   period_valid        period is a genuine measurement
//   stall               no edge for STALL_CYC cycles
//   fault               debounced code is 000 or 111
//   seq_err             1-cycle strobe on a non-adjacent legal change
module hall_sensor_conditioner
   import bldc_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 8,
   parameter int PERIOD_W     = 20,
   parameter int STALL_CYC    = 1000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                H1,
   input  logic                H2,
   input  logic                H3,
   output logic [2:0]          hall_code,
   output logic [2:0]          sector,
   output logic                sector_valid,
   output logic                edge_pulse,
   output logic                dir,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid,
   output logic                stall,
   output logic                fault,
   output logic                seq_err
);

   localparam logic [PERIOD_W-1:0] STALL_LIM = PERIOD_W'(STALL_CYC);

   function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [2:0]          code;
   logic                accept;
   logic [2:0]          new_sector;
   logic [PERIOD_W-1:0] cnt_inc;

   logic [0:0]          state_q, state_d;
   logic [2:0]          sector_q, sector_d;
   logic                sv_q, sv_d;
   logic                edge_q, edge_d;
   logic                dir_q, dir_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                pv_q, pv_d;
   logic                stall_q, stall_d;
   logic                fault_q, fault_d;
   logic                seq_q, seq_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   // One edge has been seen since the last measurement break; the next edge
   // completes a genuine period.
   logic                armed_q, armed_d;

   hall_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    ({H3, H2, H1}),
      .code_o   (code),
      .accept_o (accept)
   );

   always_comb begin
      state_d    = state_q;
      sector_d   = sector_q;
      sv_d       = sv_q;
      edge_d     = 1'b0;
      dir_d      = dir_q;
      period_d   = period_q;
      pv_d       = pv_q;
      stall_d    = stall_q;
      fault_d    = fault_q;
      seq_d      = 1'b0;
      armed_d    = armed_q;
      new_sector = hall_to_sector(code);
      cnt_inc    = sat_inc(cnt_q);
      // Counter stops at the stall limit so stall stays asserted until an edge.
      cnt_d      = (cnt_q >= STALL_LIM) ? cnt_q : cnt_inc;

      if ((cnt_d >= STALL_LIM) && !stall_q) begin
         stall_d = 1'b1;
         pv_d    = 1'b0;
         armed_d = 1'b0;
      end

      if (accept) begin
         if (!hall_legal(code)) begin
            fault_d  = 1'b1;
            sector_d = SECTOR_NONE;
            sv_d     = 1'b0;
            pv_d     = 1'b0;
            armed_d  = 1'b0;
            state_d  = ST_ACQUIRE;
         end else if (state_q == ST_ACQUIRE) begin
            fault_d  = 1'b0;
            sector_d = new_sector;
            sv_d     = 1'b1;
            pv_d     = 1'b0;
            armed_d  = 1'b0;
            cnt_d    = '0;
            state_d  = ST_TRACK;
         end else if ((new_sector == sector_next(sector_q)) ||
                      (new_sector == sector_prev(sector_q))) begin
            edge_d   = 1'b1;
            dir_d    = (new_sector == sector_next(sector_q));
            sector_d = new_sector;
            period_d = cnt_inc;
            cnt_d    = '0;
            stall_d  = 1'b0;
            pv_d     = armed_q;
            armed_d  = 1'b1;
         end else begin
            seq_d    = 1'b1;
            sector_d = new_sector;
            pv_d     = 1'b0;
            armed_d  = 1'b0;
            cnt_d    = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_ACQUIRE;
         sector_q <= SECTOR_NONE;
         sv_q     <= 1'b0;
         edge_q   <= 1'b0;
         dir_q    <= 1'b1;
         period_q <= '0;
         pv_q     <= 1'b0;
         stall_q  <= 1'b0;
         fault_q  <= 1'b0;
         seq_q    <= 1'b0;
         cnt_q    <= '0;
         armed_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         sector_q <= sector_d;
         sv_q     <= sv_d;
         edge_q   <= edge_d;
         dir_q    <= dir_d;
         period_q <= period_d;
         pv_q     <= pv_d;
         stall_q  <= stall_d;
         fault_q  <= fault_d;
         seq_q    <= seq_d;
         cnt_q    <= cnt_d;
         armed_q  <= armed_d;
      end
   end

   assign hall_code    = code;
   assign sector       = sector_q;
   assign sector_valid = sv_q;
   assign edge_pulse   = edge_q;
   assign dir          = dir_q;
   assign period       = period_q;
   assign period_valid = pv_q;
   assign stall        = stall_q;
   assign fault        = fault_q;
   assign seq_err      = seq_q;

endmodule

// File: tb/tb_hall_sensor_conditioner.sv
// Bench for hall_sensor_conditioner: clk 20 ns, DEBOUNCE_CYC=8, STALL_CYC=200.
module tb_hall_sensor_conditioner;

   localparam int PW = 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          H1 = 1'b0, H2 = 1'b0, H3 = 1'b0;
   logic [2:0]    hall_code, sector;
   logic          sector_valid, edge_pulse, dir, period_valid, stall, fault, seq_err;
   logic [PW-1:0] period;

   int checks = 0;
   int errors = 0;

   always #10 clk = ~clk;

   hall_sensor_conditioner #(.DEBOUNCE_CYC(8), .PERIOD_W(PW), .STALL_CYC(200)) dut (
      .clk(clk), .rst_n(rst_n), .H1(H1), .H2(H2), .H3(H3),
      .hall_code(hall_code), .sector(sector), .sector_valid(sector_valid),
      .edge_pulse(edge_pulse), .dir(dir), .period(period), .period_valid(period_valid),
      .stall(stall), .fault(fault), .seq_err(seq_err)
   );

   typedef struct {
      string         name;
      logic [2:0]    sec;
      logic          sv, flt, dr, edg, seq, pv, chk_per;
      logic [PW-1:0] per;
   } exp_t;

   exp_t sb[$];
   logic [2:0] fwd [6] = '{3'b001, 3'b101, 3'b100, 3'b110, 3'b010, 3'b011};

   function automatic exp_t mk(input string n, input logic [2:0] s, input logic sv,
                               input logic flt, input logic dr, input logic edg,
                               input logic seq, input logic pv, input logic chk,
                               input int per);
      exp_t e;
      e.name = n; e.sec = s; e.sv = sv; e.flt = flt; e.dr = dr; e.edg = edg;
      e.seq = seq; e.pv = pv; e.chk_per = chk; e.per = PW'(per);
      return e;
   endfunction

   function automatic logic [32:0] out_vec();
      return {hall_code, sector, sector_valid, edge_pulse, dir, period,
              period_valid, stall, fault, seq_err};
   endfunction

   // Drives a code at a falling edge, waits for the output event, compares the
   // queued expectation, then holds the code for the rest of 'hold' cycles.
   task automatic step(input logic [2:0] code, input int hold, input exp_t e);
      exp_t x;
      logic [4:0] snap;
      int hc_lat, ev_lat, extra, used;
      snap = {sector, sector_valid, fault};
      {H3, H2, H1} = code;
      sb.push_back(e);
      hc_lat = -1;
      ev_lat = -1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (hc_lat < 0 && hall_code === code) hc_lat = i;
         if (edge_pulse || seq_err || ({sector, sector_valid, fault} !== snap)) begin
            ev_lat = i;
            break;
         end
      end
      x = sb.pop_front();
      checks++;
      if (ev_lat !== 11) begin errors++; $display("FAIL %s event latency got %0d want 11", x.name, ev_lat); end
      checks++;
      if (hc_lat !== 10) begin errors++; $display("FAIL %s hall_code latency got %0d want 10", x.name, hc_lat); end
      checks++;
      if (sector !== x.sec) begin errors++; $display("FAIL %s sector got %0d want %0d", x.name, sector, x.sec); end
      checks++;
      if ({sector_valid, fault, dir} !== {x.sv, x.flt, x.dr}) begin
         errors++; $display("FAIL %s sv/fault/dir got %b want %b", x.name, {sector_valid, fault, dir}, {x.sv, x.flt, x.dr});
      end
      checks++;
      if ({edge_pulse, seq_err} !== {x.edg, x.seq}) begin
         errors++; $display("FAIL %s edge/seq_err got %b want %b", x.name, {edge_pulse, seq_err}, {x.edg, x.seq});
      end
      checks++;
      if (period_valid !== x.pv) begin errors++; $display("FAIL %s period_valid got %b want %b", x.name, period_valid, x.pv); end
      if (x.chk_per) begin
         checks++;
         if (period !== x.per) begin errors++; $display("FAIL %s period got %0d want %0d", x.name, period, x.per); end
      end
      used = (ev_lat < 0) ? 30 : ev_lat;
      extra = 0;
      for (int i = used + 1; i <= hold; i++) begin
         @(negedge clk);
         if (edge_pulse || seq_err) extra++;
      end
      checks++;
      if (extra !== 0) begin errors++; $display("FAIL %s extra strobes got %0d want 0", x.name, extra); end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (out_vec() !== {3'b000, 3'b111, 1'b0, 1'b0, 1'b1, {PW{1'b0}}, 4'b0000}) begin
         errors++; $display("FAIL reset outputs got %h want %h", out_vec(),
                             {3'b000, 3'b111, 1'b0, 1'b0, 1'b1, {PW{1'b0}}, 4'b0000});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_forward();
      for (int i = 0; i < 6; i++)
         step(fwd[i], 50, mk($sformatf("fwd%0d", i), 3'(i), 1'b1, 1'b0, 1'b1,
                             i > 0, 1'b0, i >= 2, i >= 2, 50));
   endtask

   task automatic test_reverse();
      for (int i = 4; i >= 0; i--)
         step(fwd[i], 50, mk($sformatf("rev%0d", i), 3'(i), 1'b1, 1'b0, 1'b0,
                             1'b1, 1'b0, 1'b1, 1'b1, 50));
   endtask

   task automatic test_glitch();
      int hc_moves, edges;
      hc_moves = 0;
      edges = 0;
      {H3, H2, H1} = 3'b101;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (hall_code !== 3'b001) hc_moves++;
         if (edge_pulse) edges++;
      end
      {H3, H2, H1} = 3'b001;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (hall_code !== 3'b001) hc_moves++;
         if (edge_pulse) edges++;
      end
      checks++;
      if (hc_moves !== 0) begin errors++; $display("FAIL glitch hall_code moved %0d cycles want 0", hc_moves); end
      checks++;
      if (edges !== 0) begin errors++; $display("FAIL glitch edge_pulse count %0d want 0", edges); end
   endtask

   task automatic test_fault();
      step(3'b111, 20, mk("fault111", 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
      step(3'b001, 50, mk("acquire", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
   endtask

   task automatic test_skip();
      step(3'b101, 50, mk("pre1", 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0));
      step(3'b001, 50, mk("pre0", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 50));
      step(3'b100, 50, mk("skip", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0));
   endtask

   task automatic test_stall();
      int n, waited;
      step(3'b110, 50, mk("st3", 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0));
      step(3'b010, 50, mk("st4", 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 50));
      {H3, H2, H1} = 3'b011;
      waited = 0;
      while (!edge_pulse && waited < 30) begin @(negedge clk); waited++; end
      checks++;
      if (!edge_pulse || sector !== 3'd5 || period_valid !== 1'b1) begin
         errors++; $display("FAIL stall_edge edge/sector/pv got %b/%0d/%b want 1/5/1", edge_pulse, sector, period_valid);
      end
      n = 0;
      while (n < 300) begin
         @(negedge clk);
         n++;
         if (stall) break;
      end
      checks++;
      if (n !== 200) begin errors++; $display("FAIL stall_time got %0d cycles want 200", n); end
      checks++;
      if (period_valid !== 1'b0) begin errors++; $display("FAIL stall_pv got %b want 0", period_valid); end
      repeat (50) @(negedge clk);
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL stall_hold got %b want 1", stall); end
      step(3'b010, 50, mk("unstall", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL stall_clear got %b want 0", stall); end
      step(3'b110, 50, mk("restore", 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 50));
   endtask

   task automatic test_reset_mid();
      step(3'b100, 50, mk("pre_rst", 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 50));
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (out_vec() !== {3'b000, 3'b111, 1'b0, 1'b0, 1'b1, {PW{1'b0}}, 4'b0000}) begin
         errors++; $display("FAIL reset_mid outputs got %h want %h", out_vec(),
                             {3'b000, 3'b111, 1'b0, 1'b0, 1'b1, {PW{1'b0}}, 4'b0000});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_forward();
      test_reverse();
      test_glitch();
      test_fault();
      test_skip();
      test_stall();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
